// File: rtl/ex_div_unit.sv
// ex_div_unit: iterative RV32M divider (DIV/DIVU/REM/REMU).
// Radix-2 restoring division that produces one quotient bit per clock.
// Execute starts an operation and stalls while busy_o is high.
// When the operation finishes, ready_o pulses for one cycle with the result and its destination register.
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous reset, active low
//   start_i      request, sampled only while idle
//   abort_i      flush; cancels an in-flight op, overrides start_i
//   op_i         00 DIV, 01 DIVU, 10 REM, 11 REMU
//   dividend_i   rs1 value
//   divisor_i    rs2 value
//   reg_waddr_i  destination register
//   busy_o       operation in flight
//   ready_o      one-cycle pulse, result_o/reg_waddr_o valid
//   result_o     quotient or remainder (held until next completion)
//   reg_waddr_o  destination register of the completed op
module ex_div_unit #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [1:0]            op_i,
  input  logic [DATA_W-1:0]     dividend_i,
  input  logic [DATA_W-1:0]     divisor_i,
  input  logic [REG_ADDR_W-1:0] reg_waddr_i,
  output logic                  busy_o,
  output logic                  ready_o,
  output logic [DATA_W-1:0]     result_o,
  output logic [REG_ADDR_W-1:0] reg_waddr_o
);

  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_CALC  = 2'd2,
    S_END   = 2'd3
  } state_t;

  state_t                     r_state;
  state_t                     w_next;

  logic [1:0]                 r_op;
  logic signed [DATA_W-1:0]   r_dividend;
  logic signed [DATA_W-1:0]   r_divisor;
  logic [REG_ADDR_W-1:0]      r_waddr;
  // r_a starts as |dividend| and is shifted left each iteration.
  // Quotient bits enter at the bottom, so it ends up holding the magnitude quotient.
  logic [DATA_W-1:0]          r_a;
  logic [DATA_W-1:0]          r_b;
  logic [DATA_W-1:0]          r_rem;
  logic [CNT_W-1:0]           r_count;

  logic                       r_busy;
  logic                       r_ready;
  logic [DATA_W-1:0]          r_result;
  logic [REG_ADDR_W-1:0]      r_waddr_out;

  logic                       w_signed;
  logic                       w_is_rem;
  logic                       w_div_zero;
  logic [DATA_W:0]            w_rem_shift;
  logic                       w_ge;
  logic [DATA_W-1:0]          w_rem_sub;
  logic [DATA_W-1:0]          w_quot_fix;
  logic [DATA_W-1:0]          w_rem_fix;
  logic [DATA_W-1:0]          w_result;

  function automatic logic [DATA_W-1:0] f_neg(input logic [DATA_W-1:0] v);
    return ~v + 1'b1;
  endfunction

  function automatic logic [DATA_W-1:0] f_abs(input logic signed [DATA_W-1:0] v,
                                              input logic                     en);
    return (en && v[DATA_W-1]) ? f_neg(v) : v;
  endfunction

  assign w_signed   = ~r_op[0];
  assign w_is_rem   = r_op[1];
  assign w_div_zero = (r_divisor == '0);

  // The partial remainder is always below |b| before the shift, so the shifted value fits in DATA_W+1 bits.
  // The difference fits back into DATA_W bits.
  assign w_rem_shift = {r_rem, r_a[DATA_W-1]};
  assign w_ge        = (w_rem_shift >= {1'b0, r_b});
  assign w_rem_sub   = w_rem_shift[DATA_W-1:0] - r_b;

  // Sign correction. The 0x80000000 / -1 overflow needs no special case here.
  // Negating 0x80000000 wraps back to itself, and the remainder is 0.
  assign w_quot_fix = (w_signed && (r_dividend[DATA_W-1] ^ r_divisor[DATA_W-1])) ?
                      f_neg(r_a) : r_a;
  assign w_rem_fix  = (w_signed && r_dividend[DATA_W-1]) ? f_neg(r_rem) : r_rem;

  always_comb begin
    w_result = w_is_rem ? w_rem_fix : w_quot_fix;
    if (w_div_zero) begin
      w_result = w_is_rem ? r_dividend : '1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start_i && !abort_i) w_next = S_START;
      end
      S_START: begin
        if (abort_i)         w_next = S_IDLE;
        else if (w_div_zero) w_next = S_END;
        else                 w_next = S_CALC;
      end
      S_CALC: begin
        if (abort_i)                                w_next = S_IDLE;
        else if (r_count == CNT_W'(DATA_W - 1))     w_next = S_END;
      end
      S_END: begin
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_op        <= '0;
      r_dividend  <= '0;
      r_divisor   <= '0;
      r_waddr     <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_rem       <= '0;
      r_count     <= '0;
      r_busy      <= 1'b0;
      r_ready     <= 1'b0;
      r_result    <= '0;
      r_waddr_out <= '0;
    end else begin
      r_ready <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_i && !abort_i) begin
            r_op       <= op_i;
            r_dividend <= dividend_i;
            r_divisor  <= divisor_i;
            r_waddr    <= reg_waddr_i;
            r_busy     <= 1'b1;
          end
        end
        S_START: begin
          if (abort_i) begin
            r_busy <= 1'b0;
          end else begin
            r_a     <= f_abs(r_dividend, w_signed);
            r_b     <= f_abs(r_divisor, w_signed);
            r_rem   <= '0;
            r_count <= '0;
          end
        end
        S_CALC: begin
          if (abort_i) begin
            r_busy <= 1'b0;
          end else begin
            r_rem   <= w_ge ? w_rem_sub : w_rem_shift[DATA_W-1:0];
            r_a     <= {r_a[DATA_W-2:0], w_ge};
            r_count <= r_count + CNT_W'(1);
          end
        end
        S_END: begin
          r_busy <= 1'b0;
          if (!abort_i) begin
            r_ready     <= 1'b1;
            r_result    <= w_result;
            r_waddr_out <= r_waddr;
          end
        end
        default: r_busy <= 1'b0;
      endcase
    end
  end

  assign busy_o      = r_busy;
  assign ready_o     = r_ready;
  assign result_o    = r_result;
  assign reg_waddr_o = r_waddr_out;

endmodule

// File: tb/tb_ex_div_unit.sv
module tb_ex_div_unit;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic        abort_i;
  logic [1:0]  op_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic [4:0]  reg_waddr_i;
  logic        busy_o;
  logic        ready_o;
  logic [31:0] result_o;
  logic [4:0]  reg_waddr_o;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  ex_div_unit #(.DATA_W(32), .REG_ADDR_W(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .abort_i     (abort_i),
    .op_i        (op_i),
    .dividend_i  (dividend_i),
    .divisor_i   (divisor_i),
    .reg_waddr_i (reg_waddr_i),
    .busy_o      (busy_o),
    .ready_o     (ready_o),
    .result_o    (result_o),
    .reg_waddr_o (reg_waddr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called just after a rising edge with the DUT idle.
  // Launches one op and waits up to 100 edges for ready_o.
  // lat is the edge index (E0 = accept) after which ready_o was seen, or -1.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, output int lat, output logic [31:0] res,
                       output logic [4:0] wa, output logic busy_e0);
    start_i     = 1'b1;
    op_i        = op;
    dividend_i  = a;
    divisor_i   = b;
    reg_waddr_i = rd;
    @(posedge clk); #1;
    start_i    = 1'b0;
    dividend_i = 32'hDEAD_BEEF;
    divisor_i  = 32'h0000_0003;
    busy_e0    = busy_o;
    lat = -1;
    res = 'x;
    wa  = 'x;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (ready_o) begin
        lat = n;
        res = result_o;
        wa  = reg_waddr_o;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start_i = 1'b0; abort_i = 1'b0; op_i = 2'b00;
    dividend_i = '0; divisor_i = '0; reg_waddr_i = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", ready_o); end
    checks++; if (result_o !== 32'h0) begin errors++; $display("FAIL reset_result: got %h want 0", result_o); end
    checks++; if (reg_waddr_o !== 5'h0) begin errors++; $display("FAIL reset_waddr: got %h want 0", reg_waddr_o); end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_div_basic();
    int lat; logic [31:0] res; logic [4:0] wa; logic b0;
    do_op(OP_DIV, 32'd100, 32'd7, 5'd5, lat, res, wa, b0);
    checks++; if (b0 !== 1'b1) begin errors++; $display("FAIL div_busy_e0: got %b want 1", b0); end
    checks++; if (lat != 34) begin errors++; $display("FAIL div_latency: got %0d want 34", lat); end
    checks++; if (res !== 32'd14) begin errors++; $display("FAIL div_100_7: got %h want %h", res, 32'd14); end
    checks++; if (wa !== 5'd5) begin errors++; $display("FAIL div_waddr: got %0d want 5", wa); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL div_busy_done: got %b want 0", busy_o); end
    @(posedge clk); #1;
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL div_ready_pulse: got %b want 0", ready_o); end
    checks++; if (result_o !== 32'd14) begin errors++; $display("FAIL div_result_hold: got %h want %h", result_o, 32'd14); end
  endtask

  task automatic test_signed();
    int lat; logic [31:0] res; logic [4:0] wa; logic b0;
    do_op(OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd1, lat, res, wa, b0);
    checks++; if (res !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rem_m7_2: got %h want ffffffff", res); end
    do_op(OP_DIVU, 32'hFFFF_FFFF, 32'd16, 5'd2, lat, res, wa, b0);
    checks++; if (res !== 32'h0FFF_FFFF) begin errors++; $display("FAIL divu_max_16: got %h want 0fffffff", res); end
    do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd3, lat, res, wa, b0);
    checks++; if (res !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_m7_2: got %h want fffffffd", res); end
    do_op(OP_REMU, 32'd100, 32'd7, 5'd4, lat, res, wa, b0);
    checks++; if (res !== 32'd2) begin errors++; $display("FAIL remu_100_7: got %h want 2", res); end
    do_op(OP_REM, 32'd7, 32'hFFFF_FFFE, 5'd6, lat, res, wa, b0);
    checks++; if (res !== 32'd1) begin errors++; $display("FAIL rem_7_m2: got %h want 1", res); end
    checks++; if (wa !== 5'd6) begin errors++; $display("FAIL rem_waddr: got %0d want 6", wa); end
  endtask

  task automatic test_div_zero();
    int lat; logic [31:0] res; logic [4:0] wa; logic b0;
    do_op(OP_DIVU, 32'd1234, 32'd0, 5'd7, lat, res, wa, b0);
    checks++; if (res !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu_by0: got %h want ffffffff", res); end
    checks++; if (lat != 2) begin errors++; $display("FAIL divu_by0_latency: got %0d want 2", lat); end
    do_op(OP_REM, 32'd1234, 32'd0, 5'd8, lat, res, wa, b0);
    checks++; if (res !== 32'd1234) begin errors++; $display("FAIL rem_by0: got %h want %h", res, 32'd1234); end
    checks++; if (lat != 2) begin errors++; $display("FAIL rem_by0_latency: got %0d want 2", lat); end
    do_op(OP_DIV, 32'hFFFF_FFFB, 32'd0, 5'd9, lat, res, wa, b0);
    checks++; if (res !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_neg_by0: got %h want ffffffff", res); end
    do_op(OP_REM, 32'hFFFF_FFFB, 32'd0, 5'd9, lat, res, wa, b0);
    checks++; if (res !== 32'hFFFF_FFFB) begin errors++; $display("FAIL rem_neg_by0: got %h want fffffffb", res); end
  endtask

  task automatic test_overflow();
    int lat; logic [31:0] res; logic [4:0] wa; logic b0;
    do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, lat, res, wa, b0);
    checks++; if (res !== 32'h8000_0000) begin errors++; $display("FAIL div_overflow: got %h want 80000000", res); end
    checks++; if (lat != 34) begin errors++; $display("FAIL div_overflow_latency: got %0d want 34", lat); end
    do_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, lat, res, wa, b0);
    checks++; if (res !== 32'h0) begin errors++; $display("FAIL rem_overflow: got %h want 0", res); end
  endtask

  task automatic test_abort();
    int lat; logic [31:0] res; logic [4:0] wa; logic b0;
    logic [31:0] prior;
    int pulses;
    prior = result_o;
    start_i = 1'b1; op_i = OP_DIVU; dividend_i = 32'd500; divisor_i = 32'd5; reg_waddr_i = 5'd12;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL abort_busy_before: got %b want 1", busy_o); end
    abort_i = 1'b1;
    @(posedge clk); #1;
    abort_i = 1'b0;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL abort_busy_after: got %b want 0", busy_o); end
    pulses = 0;
    repeat (40) begin @(posedge clk); #1; if (ready_o) pulses++; end
    checks++; if (pulses != 0) begin errors++; $display("FAIL abort_no_ready: got %0d pulses want 0", pulses); end
    checks++; if (result_o !== prior) begin errors++; $display("FAIL abort_result_kept: got %h want %h", result_o, prior); end
    do_op(OP_DIVU, 32'd500, 32'd5, 5'd13, lat, res, wa, b0);
    checks++; if (res !== 32'd100 || lat != 34) begin errors++; $display("FAIL abort_next_op: got %h lat %0d want 64 lat 34", res, lat); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] res; logic [4:0] wa; logic b0;
    int pulses;
    do_op(OP_DIVU, 32'd1000, 32'd10, 5'd3, lat, res, wa, b0);
    checks++; if (res !== 32'd100) begin errors++; $display("FAIL b2b_first: got %h want %h", res, 32'd100); end
    // Still in the ready_o cycle: next op is launched right here.
    do_op(OP_REMU, 32'd1000, 32'd7, 5'd9, lat, res, wa, b0);
    checks++; if (b0 !== 1'b1) begin errors++; $display("FAIL b2b_busy_reassert: got %b want 1", b0); end
    checks++; if (lat != 34) begin errors++; $display("FAIL b2b_latency: got %0d want 34", lat); end
    checks++; if (res !== 32'd6 || wa !== 5'd9) begin errors++; $display("FAIL b2b_second: got %h rd %0d want 6 rd 9", res, wa); end
    // A start request while busy must be dropped.
    start_i = 1'b1; op_i = OP_DIVU; dividend_i = 32'd81; divisor_i = 32'd9; reg_waddr_i = 5'd14;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    start_i = 1'b1; op_i = OP_REMU; dividend_i = 32'd55; divisor_i = 32'd10; reg_waddr_i = 5'd15;
    @(posedge clk); #1;
    start_i = 1'b0;
    pulses = 0; res = 'x; wa = 'x;
    repeat (60) begin
      @(posedge clk); #1;
      if (ready_o) begin pulses++; res = result_o; wa = reg_waddr_o; end
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL busy_start_ignored_pulses: got %0d want 1", pulses); end
    checks++; if (res !== 32'd9 || wa !== 5'd14) begin errors++; $display("FAIL busy_start_ignored: got %h rd %0d want 9 rd 14", res, wa); end
  endtask

  task automatic test_reset_mid();
    int pulses;
    start_i = 1'b1; op_i = OP_DIV; dividend_i = 32'd77; divisor_i = 32'd7; reg_waddr_i = 5'd20;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (20) begin @(posedge clk); #1; end
    rst = 1'b0;
    #1;
    checks++; if (busy_o !== 1'b0 || ready_o !== 1'b0) begin errors++; $display("FAIL rst_mid_ctrl: got busy %b ready %b want 0 0", busy_o, ready_o); end
    checks++; if (result_o !== 32'h0 || reg_waddr_o !== 5'h0) begin errors++; $display("FAIL rst_mid_data: got %h rd %0d want 0 rd 0", result_o, reg_waddr_o); end
    @(posedge clk); #1;
    rst = 1'b1;
    pulses = 0;
    repeat (40) begin @(posedge clk); #1; if (ready_o || busy_o) pulses++; end
    checks++; if (pulses != 0) begin errors++; $display("FAIL rst_mid_no_pulse: got %0d active cycles want 0", pulses); end
  endtask

  initial begin
    test_reset();
    test_div_basic();
    test_signed();
    test_div_zero();
    test_overflow();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
